// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART/IrDA receive path.
//   - rx_state_t   : receive FSM state encoding (3-bit)
//   - DEFAULT_DATA_BITS : default number of data bits per frame
//   - HALF_BIT / FULL_BIT : baud generator terminal counts (50 MHz, 9600 baud),
//                           shared with the baud generator
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int unsigned DEFAULT_DATA_BITS = 8;

    localparam logic [12:0] HALF_BIT = 13'hA2B;
    localparam logic [12:0] FULL_BIT = 13'h1457;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

endpackage : uart_pkg

// File: rtl/uart_rx_sync.sv
// ----------------------------------------------------------------------------
// uart_rx_sync
// Multi-flop synchroniser for the raw serial input. All flops reset to 1 so
// the line looks idle (high) while reset is asserted and straight after it.
// Ports:
//   i_clk    in   system clock
//   i_rst_n  in   asynchronous active-low reset
//   i_async  in   raw asynchronous serial line
//   o_sync   out  synchronised line (after SYNC_STAGES flops)
// ----------------------------------------------------------------------------
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule : uart_rx_sync

// File: rtl/uart_rx_controller.sv
// ----------------------------------------------------------------------------
// uart_rx_controller
// Receive sequencer for the UART/IrDA path. Detects the start bit, enables
// the baud generator, samples each bit on the generator's mid-bit strobe,
// assembles the frame LSB first and presents it through a valid/ack
// holding register.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : PARITY state between DATA and STOP, even parity checked,
//               parity_error pulses at the stop-bit sample on mismatch.
//   undefined : no parity bit in the frame, parity_error tied to 0.
//
// Ports:
//   clock            in   system clock
//   reset            in   asynchronous active-low reset
//   rx_in            in   raw serial line, idle high
//   half_bit_sample  in   baud generator mid-bit strobe (1 cycle)
//   full_baud        in   baud generator end-of-bit strobe (1 cycle)
//   baud_enable      out  runs the baud generator (low clears its count)
//   rx_data          out  received byte, held while rx_valid=1
//   rx_valid         out  byte available
//   rx_ack           in   consumer accepts byte
//   busy             out  frame in progress
//   framing_error    out  1-cycle pulse: stop bit sampled low
//   overrun_error    out  1-cycle pulse: frame completed while byte unread
//   parity_error     out  1-cycle pulse: parity mismatch
// ----------------------------------------------------------------------------
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = DEFAULT_DATA_BITS,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rx_in,
    input  logic                 half_bit_sample,
    input  logic                 full_baud,
    output logic                 baud_enable,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ack,
    output logic                 busy,
    output logic                 framing_error,
    output logic                 overrun_error,
    output logic                 parity_error
);

    localparam int unsigned CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_BITS);

    // ------------------------------------------------------------------
    // Input synchroniser
    // ------------------------------------------------------------------
    logic w_rx_s;

    uart_rx_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clock),
        .i_rst_n (reset),
        .i_async (rx_in),
        .o_sync  (w_rx_s)
    );

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    rx_state_t            r_state;
    logic [DATA_BITS-1:0] r_shift;
    logic [CNT_W-1:0]     r_bit_cnt;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_baud_en;
    logic                 r_busy;
    logic                 r_fe;
    logic                 r_oe;
    logic                 r_pe;

    rx_state_t            w_state;
    logic [DATA_BITS-1:0] w_shift;
    logic [CNT_W-1:0]     w_bit_cnt;
    logic [DATA_BITS-1:0] w_data;
    logic                 w_valid;
    logic                 w_fe;
    logic                 w_oe;
    logic                 w_pe;
    logic                 w_deliver;

`ifdef UART_RX_PARITY_EN
    logic r_par_bad;
    logic w_par_bad;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_baud_en <= 1'b0;
            r_busy    <= 1'b0;
            r_fe      <= 1'b0;
            r_oe      <= 1'b0;
            r_pe      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= 1'b0;
`endif
        end else begin
            r_state   <= w_state;
            r_shift   <= w_shift;
            r_bit_cnt <= w_bit_cnt;
            r_data    <= w_data;
            r_valid   <= w_valid;
            // Both track the next state so they drop in the same edge that
            // returns the FSM to IDLE (false start, end of stop bit).
            r_baud_en <= (w_state != IDLE);
            r_busy    <= (w_state != IDLE);
            r_fe      <= w_fe;
            r_oe      <= w_oe;
            r_pe      <= w_pe;
`ifdef UART_RX_PARITY_EN
            r_par_bad <= w_par_bad;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state / datapath logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state   = r_state;
        w_shift   = r_shift;
        w_bit_cnt = r_bit_cnt;
        w_data    = r_data;
        w_valid   = r_valid;
        w_fe      = 1'b0;
        w_oe      = 1'b0;
        w_pe      = 1'b0;
        w_deliver = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_bad = r_par_bad;
`endif

        if (rx_ack && r_valid) begin
            w_valid = 1'b0;
        end

        // half_bit_sample is checked first everywhere, so a simultaneous
        // full_baud is dropped.
        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state = START;
                end
            end

            START: begin
                if (half_bit_sample) begin
                    if (w_rx_s) begin
                        w_state = IDLE;
                    end
                end else if (full_baud) begin
                    w_state   = DATA;
                    w_bit_cnt = '0;
`ifdef UART_RX_PARITY_EN
                    w_par_bad = 1'b0;
`endif
                end
            end

            DATA: begin
                if (half_bit_sample) begin
                    if (r_bit_cnt != LAST_CNT) begin
                        w_shift   = {w_rx_s, r_shift[DATA_BITS-1:1]};
                        w_bit_cnt = r_bit_cnt + CNT_W'(1);
                    end
                end else if (full_baud && (r_bit_cnt == LAST_CNT)) begin
`ifdef UART_RX_PARITY_EN
                    w_state = PARITY;
`else
                    w_state = STOP;
`endif
                end
            end

`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (half_bit_sample) begin
                    w_par_bad = (w_rx_s != (^r_shift));
                end else if (full_baud) begin
                    w_state = STOP;
                end
            end
`endif

            STOP: begin
                if (half_bit_sample) begin
                    w_state = IDLE;
                    w_fe    = ~w_rx_s;
`ifdef UART_RX_PARITY_EN
                    w_pe      = r_par_bad;
                    w_deliver = w_rx_s & ~r_par_bad;
`else
                    w_deliver = w_rx_s;
`endif
                end
            end

            default: begin
                w_state = IDLE;
            end
        endcase

        // Same-cycle ack frees the holding register for the new byte.
        if (w_deliver) begin
            if (!r_valid || rx_ack) begin
                w_data  = r_shift;
                w_valid = 1'b1;
            end else begin
                w_oe = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign baud_enable   = r_baud_en;
    assign busy          = r_busy;
    assign rx_data       = r_data;
    assign rx_valid      = r_valid;
    assign framing_error = r_fe;
    assign overrun_error = r_oe;
`ifdef UART_RX_PARITY_EN
    assign parity_error  = r_pe;
`else
    assign parity_error  = 1'b0;
`endif

endmodule : uart_rx_controller

// File: tb/tb_uart_rx_controller.sv
// ----------------------------------------------------------------------------
// tb_uart_rx_controller
// Directed bench for uart_rx_controller with a shortened bit period and a
// behavioural baud generator. Expected bytes are queued as frames are sent
// and compared against bytes captured when the DUT delivers them.
// Build with +define+UART_RX_PARITY_EN to cover the parity frames.
// ----------------------------------------------------------------------------
module tb_uart_rx_controller;

    localparam int unsigned BIT_CLKS = 32;
    localparam int unsigned HALF_AT  = 15;
    localparam int unsigned FULL_AT  = 31;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned STOP_HALF = 11;
`else
    localparam int unsigned STOP_HALF = 10;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       rx_in;
    logic       half_bit_sample = 1'b0;
    logic       full_baud = 1'b0;
    logic       baud_enable;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       busy;
    logic       framing_error;
    logic       overrun_error;
    logic       parity_error;

    logic       rx_ack_user;
    logic       ack_on_stop;

    uart_rx_controller #(
        .DATA_BITS   (8),
        .SYNC_STAGES (2)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .rx_in           (rx_in),
        .half_bit_sample (half_bit_sample),
        .full_baud       (full_baud),
        .baud_enable     (baud_enable),
        .rx_data         (rx_data),
        .rx_valid        (rx_valid),
        .rx_ack          (rx_ack),
        .busy            (busy),
        .framing_error   (framing_error),
        .overrun_error   (overrun_error),
        .parity_error    (parity_error)
    );

    always #5 clock = ~clock;

    // Baud generator model: counts while enabled, cleared when disabled.
    int unsigned gen_cnt  = 0;
    int unsigned half_idx = 0;

    always @(negedge clock) begin
        if (!baud_enable) begin
            gen_cnt         = 0;
            half_idx        = 0;
            half_bit_sample = 1'b0;
            full_baud       = 1'b0;
        end else begin
            half_bit_sample = (gen_cnt == HALF_AT);
            full_baud       = (gen_cnt == FULL_AT);
            if (half_bit_sample) half_idx = half_idx + 1;
            gen_cnt = (gen_cnt == FULL_AT) ? 0 : gen_cnt + 1;
        end
    end

    assign rx_ack = rx_ack_user |
                    (ack_on_stop & half_bit_sample & (half_idx == STOP_HALF));

    // Output monitor
    logic [7:0]  obs_data [0:31];
    int unsigned n_deliv   = 0;
    int unsigned deliv_cyc = 0;
    int unsigned cyc       = 0;
    int unsigned fe_rise = 0, fe_high = 0;
    int unsigned oe_rise = 0, oe_high = 0;
    int unsigned pe_rise = 0, pe_high = 0;
    logic prev_valid = 1'b0, prev_fe = 1'b0, prev_oe = 1'b0, prev_pe = 1'b0;

    always @(posedge clock) begin
        #1;
        cyc = cyc + 1;
        if (!reset) begin
            prev_valid = 1'b0;
            prev_fe    = 1'b0;
            prev_oe    = 1'b0;
            prev_pe    = 1'b0;
        end else begin
            if (rx_valid && (!prev_valid || rx_ack)) begin
                if (n_deliv < 32) obs_data[n_deliv] = rx_data;
                n_deliv   = n_deliv + 1;
                deliv_cyc = cyc;
            end
            if (framing_error) fe_high = fe_high + 1;
            if (framing_error && !prev_fe) fe_rise = fe_rise + 1;
            if (overrun_error) oe_high = oe_high + 1;
            if (overrun_error && !prev_oe) oe_rise = oe_rise + 1;
            if (parity_error) pe_high = pe_high + 1;
            if (parity_error && !prev_pe) pe_rise = pe_rise + 1;
            prev_valid = rx_valid;
            prev_fe    = framing_error;
            prev_oe    = overrun_error;
            prev_pe    = parity_error;
        end
    end

    // Scoreboard and checking
    int unsigned checks   = 0;
    int unsigned failures = 0;
    logic [7:0]  exp_q [$];
    int unsigned exp_total = 0;
    int unsigned rd_idx    = 0;
    int unsigned start_cyc = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input logic [7:0] d);
        exp_q.push_back(d);
        exp_total = exp_total + 1;
    endtask

    task automatic sb_check(input string tag);
        check({tag, "_deliveries"}, n_deliv, exp_total);
        while (exp_q.size() > 0 && rd_idx < n_deliv && rd_idx < 32) begin
            check({tag, "_data"}, {24'd0, obs_data[rd_idx]}, {24'd0, exp_q.pop_front()});
            rd_idx = rd_idx + 1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (BIT_CLKS) @(negedge clock);
    endtask

    task automatic idle_bits(input int unsigned n);
        rx_in = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clock);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par_b);
        start_cyc = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par_b);
`else
        if (par_b === 1'bx) rx_in = 1'b1;
`endif
        drive_bit(stop_b);
        rx_in = 1'b1;
    endtask

    task automatic ack_pulse();
        rx_ack_user = 1'b1;
        @(negedge clock);
        rx_ack_user = 1'b0;
        @(negedge clock);
    endtask

    initial begin
        reset       = 1'b0;
        rx_in       = 1'b1;
        rx_ack_user = 1'b0;
        ack_on_stop = 1'b0;
        repeat (3) @(negedge clock);

        check("rst_rx_valid",    {31'd0, rx_valid},      32'd0);
        check("rst_rx_data",     {24'd0, rx_data},       32'd0);
        check("rst_baud_enable", {31'd0, baud_enable},   32'd0);
        check("rst_busy",        {31'd0, busy},          32'd0);
        check("rst_errors",      {29'd0, framing_error, overrun_error, parity_error}, 32'd0);

        reset = 1'b1;
        idle_bits(1);

        // Clean frame, latency of delivery from the start edge
        expect_byte(8'hA5);
        send_frame(8'hA5, 1'b1, ^8'hA5);
        check("a5_latency_in_window",
              {31'd0, (deliv_cyc - start_cyc >= 9 * BIT_CLKS) && (deliv_cyc - start_cyc <= 10 * BIT_CLKS)}, 32'd1);
        check("a5_busy_after_stop", {31'd0, busy}, 32'd0);
        check("a5_rx_valid", {31'd0, rx_valid}, 32'd1);
        sb_check("a5");
        ack_pulse();
        check("ack_clears_valid", {31'd0, rx_valid}, 32'd0);
        idle_bits(1);

        // Short glitch: false start
        rx_in = 1'b0;
        repeat (6) @(negedge clock);
        rx_in = 1'b1;
        repeat (2) @(negedge clock);
        check("glitch_baud_en_high", {31'd0, baud_enable}, 32'd1);
        check("glitch_busy_high",    {31'd0, busy},        32'd1);
        repeat (40) @(negedge clock);
        check("glitch_baud_en_low", {31'd0, baud_enable}, 32'd0);
        check("glitch_busy_low",    {31'd0, busy},        32'd0);
        check("glitch_no_valid",    {31'd0, rx_valid},    32'd0);
        check("glitch_no_fe",       fe_high,              32'd0);
        sb_check("glitch");

        // Framing error
        send_frame(8'h3C, 1'b0, ^8'h3C);
        idle_bits(2);
        check("fe_pulse_count", fe_rise, 32'd1);
        check("fe_pulse_width", fe_high, 32'd1);
        check("fe_no_valid",    {31'd0, rx_valid}, 32'd0);
        check("fe_busy_low",    {31'd0, busy}, 32'd0);
        sb_check("fe");

        // Back-to-back frames without ack: overrun on the second
        expect_byte(8'h11);
        send_frame(8'h11, 1'b1, ^8'h11);
        send_frame(8'h22, 1'b1, ^8'h22);
        idle_bits(1);
        check("ovr_pulse_count", oe_rise, 32'd1);
        check("ovr_pulse_width", oe_high, 32'd1);
        check("ovr_data_kept",   {24'd0, rx_data}, 32'h11);
        check("ovr_valid_held",  {31'd0, rx_valid}, 32'd1);
        sb_check("ovr");

        // Ack on the stop-sample cycle frees the register for the new byte
        ack_on_stop = 1'b1;
        expect_byte(8'h33);
        send_frame(8'h33, 1'b1, ^8'h33);
        ack_on_stop = 1'b0;
        idle_bits(1);
        check("ackstop_no_overrun", oe_rise, 32'd1);
        check("ackstop_data",       {24'd0, rx_data}, 32'h33);
        sb_check("ackstop");
        ack_pulse();

        // Reset during data bit 4
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(i[0]);
        rx_in = 1'b1;
        repeat (10) @(negedge clock);
        reset = 1'b0;
        #1;
        check("midrst_rx_data",     {24'd0, rx_data},     32'd0);
        check("midrst_rx_valid",    {31'd0, rx_valid},    32'd0);
        check("midrst_baud_enable", {31'd0, baud_enable}, 32'd0);
        check("midrst_busy",        {31'd0, busy},        32'd0);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        idle_bits(2);
        expect_byte(8'h7E);
        send_frame(8'h7E, 1'b1, ^8'h7E);
        idle_bits(1);
        sb_check("after_rst");
        ack_pulse();

`ifdef UART_RX_PARITY_EN
        expect_byte(8'h07);
        send_frame(8'h07, 1'b1, 1'b1);
        idle_bits(1);
        check("par_ok_no_pe", pe_rise, 32'd0);
        sb_check("par_ok");
        ack_pulse();
        send_frame(8'h07, 1'b1, 1'b0);
        idle_bits(1);
        check("par_bad_pe_count", pe_rise, 32'd1);
        check("par_bad_pe_width", pe_high, 32'd1);
        check("par_bad_no_valid", {31'd0, rx_valid}, 32'd0);
        sb_check("par_bad");
`else
        check("parity_error_tied_low", pe_high, 32'd0);
`endif

        check("sb_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_controller
